pulse_pattern_gen: RTL and testbench

Downstream stage of the event generator. Accepts one event per frame (valid flag plus four 10-bit delay words x1/x2/y1/y2) and turns it into four timed detector pulses. Each delay word carries a coarse delay in clock cycles in bits [9:3] and a 1/8-cycle fine code in bits [2:0]. The block emits the coarse-timed pulses and holds the fine codes for the external fine-delay taps, one frame of FRAME_CYCLES cycles (1 MHz event rate at 100 MHz).

---
 rtl/ppg_pkg.sv | 23 ++
 rtl/ppg_channel.sv | 41 ++++
 rtl/pulse_pattern_gen.sv | 125 ++++++++++++
 tb/tb_pulse_pattern_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared types, widths and delay-word field helpers for the pulse pattern generator.
package ppg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NUM_CH   = 4;
    localparam int COORD_W  = 10;
    localparam int FINE_W   = 3;
    localparam int COARSE_W = 7;
    localparam int CNT_W    = 8;

    function automatic logic [COARSE_W-1:0] coarse_of(input logic [COORD_W-1:0] d);
        return d[COORD_W-1:FINE_W];
    endfunction

    function automatic logic [FINE_W-1:0] fine_of(input logic [COORD_W-1:0] d);
        return d[FINE_W-1:0];
    endfunction

endpackage

// File: rtl/ppg_channel.sv
// One detector channel: registered pulse while the frame counter sits inside
// the [coarse, coarse+PULSE_WIDTH) window.
module ppg_channel
    import ppg_pkg::*;
#(
    parameter int PULSE_WIDTH  = 4,
    parameter int FRAME_CYCLES = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CNT_W-1:0]    cnt_i,
    input  logic [COARSE_W-1:0] coarse_i,
    input  logic                run_i,
    output logic                pulse_o
);

    logic [CNT_W-1:0] start_w;
    logic [CNT_W-1:0] stop_w;
    logic             pulse_d;
    logic             pulse_q;

    // 8-bit sums cannot wrap: max coarse 127 plus max width 8 stays below 256.
    assign start_w = {1'b0, coarse_i};
    assign stop_w  = start_w + CNT_W'(PULSE_WIDTH);

    assign pulse_d = run_i
                  && (start_w < CNT_W'(FRAME_CYCLES))
                  && (cnt_i >= start_w)
                  && (cnt_i < stop_w);

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pulse_pattern_gen.sv
// Frame sequencer turning one event into four coarse-timed pulses plus latched fine codes.
// Optional rejected-trigger counter enabled by defining PPG_DROP_COUNT_EN.
//   state | meaning
//   IDLE  | waiting for trig_i & valid_i
//   RUN   | frame in progress, cnt counts 0..FRAME_CYCLES-1
module pulse_pattern_gen
    import ppg_pkg::*;
#(
    parameter int PULSE_WIDTH  = 4,
    parameter int FRAME_CYCLES = 100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trig_i,
    input  logic                       valid_i,
    input  logic [COORD_W-1:0]         x1_i,
    input  logic [COORD_W-1:0]         x2_i,
    input  logic [COORD_W-1:0]         y1_i,
    input  logic [COORD_W-1:0]         y2_i,
    output logic                       busy_o,
    output logic                       frame_o,
    output logic [NUM_CH-1:0]          pulse_o,
    output logic [NUM_CH*FINE_W-1:0]   fine_o
`ifdef PPG_DROP_COUNT_EN
    ,
    output logic [15:0]                drop_cnt_o
`endif
);

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_CH-1:0][COARSE_W-1:0]    coarse_q, coarse_d;
    logic [NUM_CH*FINE_W-1:0]           fine_q, fine_d;
    logic                               frame_q, frame_d;
    logic                               run_w;

    assign run_w = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        frame_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_i && valid_i) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    coarse_d[0] = coarse_of(x1_i);
                    coarse_d[1] = coarse_of(x2_i);
                    coarse_d[2] = coarse_of(y1_i);
                    coarse_d[3] = coarse_of(y2_i);
                    fine_d      = {fine_of(y2_i), fine_of(y1_i), fine_of(x2_i), fine_of(x1_i)};
                end
            end
            RUN: begin
                frame_d = (cnt_q == '0);
                if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            coarse_q <= '0;
            fine_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            frame_q  <= frame_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ppg_channel #(
            .PULSE_WIDTH  (PULSE_WIDTH),
            .FRAME_CYCLES (FRAME_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cnt_i    (cnt_q),
            .coarse_i (coarse_q[g]),
            .run_i    (run_w),
            .pulse_o  (pulse_o[g])
        );
    end

    assign busy_o  = run_w;
    assign frame_o = frame_q;
    assign fine_o  = fine_q;

`ifdef PPG_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    // The return-to-IDLE cycle is still RUN, so its trigger counts as dropped.
    always_comb begin
        drop_d = drop_q;
        if (run_w && trig_i && valid_i && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// Scoreboard bench for pulse_pattern_gen: stimulus pushes expected per-cycle
// snapshots and frame markers, a negedge monitor pops and compares.
module tb_pulse_pattern_gen;

    localparam int FC = 100;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig = 1'b0;
    logic        valid = 1'b0;
    logic [9:0]  x1 = '0, x2 = '0, y1 = '0, y2 = '0;
    logic        busy, frame;
    logic [3:0]  pulse;
    logic [11:0] fine;
`ifdef PPG_DROP_COUNT_EN
    logic [15:0] drop_cnt;
`endif

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          stop = 1'b0;
    logic [11:0] cur_fine = '0;

    typedef struct {
        int          cyc;
        logic        busy;
        logic        frame;
        logic [3:0]  pulse;
        logic [11:0] fine;
    } snap_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } drop_t;

    snap_t exp_q[$];
    int    frame_q[$];
    drop_t drop_q[$];

    pulse_pattern_gen #(
        .PULSE_WIDTH  (PW),
        .FRAME_CYCLES (FC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trig_i     (trig),
        .valid_i    (valid),
        .x1_i       (x1),
        .x2_i       (x2),
        .y1_i       (y1),
        .y2_i       (y2),
        .busy_o     (busy),
        .frame_o    (frame),
        .pulse_o    (pulse),
        .fine_o     (fine)
`ifdef PPG_DROP_COUNT_EN
        ,
        .drop_cnt_o (drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_in(input logic t, input logic v,
                          input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] d);
        trig = t; valid = v; x1 = a; x2 = b; y1 = c; y2 = d;
    endtask

    task automatic push_idle(input int from, input int to);
        snap_t s;
        for (int t = from; t <= to; t++) begin
            s.cyc = t; s.busy = 1'b0; s.frame = 1'b0; s.pulse = 4'b0; s.fine = cur_fine;
            exp_q.push_back(s);
        end
    endtask

    // Expected outputs for a frame accepted at cycle t0, for cycles t0+1..last.
    task automatic push_frame(input int t0,
                              input logic [9:0] w0, input logic [9:0] w1,
                              input logic [9:0] w2, input logic [9:0] w3,
                              input int last);
        snap_t s;
        int    co[4];
        co[0] = int'(w0[9:3]); co[1] = int'(w1[9:3]);
        co[2] = int'(w2[9:3]); co[3] = int'(w3[9:3]);
        cur_fine = {w3[2:0], w2[2:0], w1[2:0], w0[2:0]};
        for (int t = t0 + 1; t <= last; t++) begin
            s.cyc   = t;
            s.busy  = (t <= t0 + FC);
            s.frame = (t == t0 + 2);
            for (int k = 0; k < 4; k++)
                s.pulse[k] = (co[k] < FC) && (t >= t0 + 2 + co[k])
                          && (t <= t0 + 1 + co[k] + PW) && (t <= t0 + FC + 1);
            s.fine  = cur_fine;
            exp_q.push_back(s);
        end
        if (last >= t0 + 2) frame_q.push_back(t0 + 2);
    endtask

    // Monitor / scoreboard
    initial begin
        snap_t s;
        int    fe;
        while (!stop) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                s = exp_q.pop_front();
                total++; bad++;
                $display("FAIL snap_missed cyc=%0d expected at cyc=%0d", cyc, s.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                s = exp_q.pop_front();
                total++;
                if ({busy, frame, pulse, fine} !== {s.busy, s.frame, s.pulse, s.fine}) begin
                    bad++;
                    $display("FAIL snap cyc=%0d got busy=%b frame=%b pulse=%b fine=%h exp busy=%b frame=%b pulse=%b fine=%h",
                             cyc, busy, frame, pulse, fine, s.busy, s.frame, s.pulse, s.fine);
                end
            end
            if (frame === 1'b1) begin
                total++;
                if (frame_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_unexpected cyc=%0d got frame_o=1 exp none", cyc);
                end else begin
                    fe = frame_q.pop_front();
                    if (fe != cyc) begin
                        bad++;
                        $display("FAIL frame_time got cyc=%0d exp cyc=%0d", cyc, fe);
                    end
                end
            end
`ifdef PPG_DROP_COUNT_EN
            if (drop_q.size() > 0 && drop_q[0].cyc == cyc) begin
                drop_t d;
                d = drop_q.pop_front();
                total++;
                if (drop_cnt !== d.val) begin
                    bad++;
                    $display("FAIL drop_cnt cyc=%0d got %0d exp %0d", cyc, drop_cnt, d.val);
                end
            end
`endif
        end
        total++;
        if (exp_q.size() != 0 || frame_q.size() != 0 || drop_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained got snaps=%0d frames=%0d drops=%0d exp 0 0 0",
                     exp_q.size(), frame_q.size(), drop_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp finish before time limit", cyc);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int t0, t1;

        // reset
        tick(); tick(); tick();
        push_idle(cyc, cyc + 3);
        reset = 1'b0;
        tick(); tick(); tick(); tick();

        // A: all channels coarse 10, fine 0
        t0 = cyc;
        push_frame(t0, 10'd80, 10'd80, 10'd80, 10'd80, t0 + FC + 1);
        push_idle(t0 + FC + 2, t0 + FC + 3);
        set_in(1, 1, 10'd80, 10'd80, 10'd80, 10'd80);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t0 + FC + 3);

        // B: trigger without valid leaves everything alone
        t0 = cyc;
        push_idle(t0 + 1, t0 + 5);
        set_in(1, 0, 10'd7, 10'd7, 10'd7, 10'd7);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t0 + 6);

        // C: late pulse, out-of-frame coarse, ignored triggers, back-to-back frame
        t0 = cyc;
        push_frame(t0, 10'd763, 10'd1023, 10'd1023, 10'd1023, t0 + FC + 1);
`ifdef PPG_DROP_COUNT_EN
        drop_q.push_back('{t0 + 51, 16'd1});
        drop_q.push_back('{t0 + 101, 16'd2});
`endif
        set_in(1, 1, 10'd763, 10'd1023, 10'd1023, 10'd1023);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t0 + 50);
        set_in(1, 1, 10'd0, 10'd0, 10'd0, 10'd0);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t0 + 100);
        set_in(1, 1, 10'd5, 10'd5, 10'd5, 10'd5);
        tick();
        t1 = cyc;
        push_frame(t1, 10'd790, 10'd0, 10'd16, 10'd797, t1 + FC + 1);
        push_idle(t1 + FC + 2, t1 + FC + 3);
        set_in(1, 1, 10'd790, 10'd0, 10'd16, 10'd797);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t1 + FC + 3);

        // D: reset in the middle of a pulse, then a normal trigger
        t0 = cyc;
        push_frame(t0, 10'd85, 10'd85, 10'd85, 10'd85, t0 + 12);
        set_in(1, 1, 10'd85, 10'd85, 10'd85, 10'd85);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t0 + 12);
        reset = 1'b1;
        cur_fine = '0;
        push_idle(t0 + 13, t0 + 14);
`ifdef PPG_DROP_COUNT_EN
        drop_q.push_back('{t0 + 13, 16'd0});
`endif
        tick();
        reset = 1'b0;
        tick();
        t1 = cyc;
        push_frame(t1, 10'd0, 10'd0, 10'd0, 10'd0, t1 + FC + 1);
        push_idle(t1 + FC + 2, t1 + FC + 3);
        set_in(1, 1, 10'd0, 10'd0, 10'd0, 10'd0);
        tick();
        set_in(0, 0, '0, '0, '0, '0);
        wait_to(t1 + FC + 4);

        stop = 1'b1;
    end

endmodule
